// File: rtl/vga_scan_ctrl.sv
// 640x480@60 VGA scan generator: drives (x, y) to the layers, samples their answer at pixel end,
// and registers rgb/hs/vs/frame_clk together so they lag x/y by exactly one pixel period.
module vga_scan_ctrl #(
    parameter int unsigned PIX_DIV       = 4,
    parameter int unsigned LAYER_LATENCY = 2,
    parameter int unsigned H_ACTIVE      = 640,
    parameter int unsigned H_FP          = 16,
    parameter int unsigned H_SYNC        = 96,
    parameter int unsigned H_BP          = 48,
    parameter int unsigned V_ACTIVE      = 480,
    parameter int unsigned V_FP          = 10,
    parameter int unsigned V_SYNC        = 2,
    parameter int unsigned V_BP          = 33
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        layer_valid,
    input  logic [11:0] layer_color,
    input  logic [11:0] bg_color,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        hs,
    output logic        vs,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b,
    output logic        frame_clk
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
    localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]    H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0]    V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]    HS_BEG   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]    HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]    VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]    VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    // The layer answer must settle before the pixel-end sample point.
    if (LAYER_LATENCY > PIX_DIV - 1) begin : g_latency_check
        $error("LAYER_LATENCY must not exceed PIX_DIV-1");
    end

    logic [DW-1:0] div_q, div_d;
    logic [9:0]    x_q, x_d;
    logic [9:0]    y_q, y_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic [11:0]   rgb_q, rgb_d;
    logic          fc_q, fc_d;
    logic          pix_end;
    logic          active;

    assign pix_end = (div_q == DIV_LAST);
    assign active  = (x_q < H_ACT) && (y_q < V_ACT);

    always_comb begin
        div_d = pix_end ? '0 : div_q + DW'(1);
        x_d   = x_q;
        y_d   = y_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        rgb_d = rgb_q;
        fc_d  = fc_q;
        if (pix_end) begin
            // Outputs describe the pixel being left, so they trail x/y by one pixel.
            rgb_d = active ? (layer_valid ? layer_color : bg_color) : 12'h000;
            hs_d  = !((x_q >= HS_BEG) && (x_q <= HS_END));
            vs_d  = !((y_q >= VS_BEG) && (y_q <= VS_END));
            fc_d  = (y_q >= V_ACT);
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            rgb_q <= '0;
            fc_q  <= 1'b0;
        end else begin
            div_q <= div_d;
            x_q   <= x_d;
            y_q   <= y_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            rgb_q <= rgb_d;
            fc_q  <= fc_d;
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign hs        = hs_q;
    assign vs        = vs_q;
    assign r         = rgb_q[11:8];
    assign g         = rgb_q[7:4];
    assign b         = rgb_q[3:0];
    assign frame_clk = fc_q;

endmodule
